// File: rtl/vec_mem_streamer_if.sv
// Request/handshake and memory/cache bus bundle for vec_mem_streamer.
// slave is the streamer's view; master is the environment (requester + memories).
interface vec_mem_streamer_if #(
    parameter int WIDTH              = 16,
    parameter int CACHE_SIZE         = 8,
    parameter int DATA_MEM_ADDR_SIZE = 32
);
    localparam int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE);

    logic                          start;
    logic                          mode;
    logic [DATA_MEM_ADDR_SIZE-1:0] mem_base;
    logic [DATA_MEM_ADDR_SIZE-1:0] mem_stride;
    logic [CACHE_ADDR_SIZE-1:0]    cache_base;
    logic [CACHE_ADDR_SIZE:0]      count;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [DATA_MEM_ADDR_SIZE-1:0] data_mem_read_addr;
    logic [WIDTH-1:0][31:0]        data_mem_data_out;
    logic                          data_mem_write_en;
    logic [DATA_MEM_ADDR_SIZE-1:0] data_mem_write_addr;
    logic [WIDTH-1:0][31:0]        data_mem_data_in;
    logic [CACHE_ADDR_SIZE-1:0]    cache_read_addr;
    logic [WIDTH-1:0][31:0]        cache_data_out;
    logic                          cache_write_en;
    logic [CACHE_ADDR_SIZE-1:0]    cache_write_addr;
    logic [WIDTH-1:0][31:0]        cache_data_in;

    modport slave (
        input  start, mode, mem_base, mem_stride, cache_base, count,
               data_mem_data_out, cache_data_out,
        output busy, done, error,
               data_mem_read_addr, data_mem_write_en, data_mem_write_addr, data_mem_data_in,
               cache_read_addr, cache_write_en, cache_write_addr, cache_data_in
    );

    modport master (
        output start, mode, mem_base, mem_stride, cache_base, count,
               data_mem_data_out, cache_data_out,
        input  busy, done, error,
               data_mem_read_addr, data_mem_write_en, data_mem_write_addr, data_mem_data_in,
               cache_read_addr, cache_write_en, cache_write_addr, cache_data_in
    );
endinterface

// File: rtl/vec_mem_streamer.sv
// Vector mover between a combinational-read data memory and a registered-read
// vector cache. LOAD moves one vector per cycle; STORE runs a one-deep pipeline
// (read issued one cycle ahead of the memory write).
//
// state    | meaning
// IDLE     | waiting for start; request checked and latched here only
// LOAD     | mem[mem_base+i*stride] -> cache[(cache_base+i) mod CACHE_SIZE]
// STORE_RD | first cache read issued, nothing written yet
// STORE_WR | writes vector i-1 to memory while reading cache entry i
// DONE     | one-cycle done pulse, then back to IDLE
module vec_mem_streamer #(
    parameter int WIDTH              = 16,
    parameter int CACHE_SIZE         = 8,
    parameter int DATA_MEM_ADDR_SIZE = 32
) (
    input logic             clock,
    input logic             reset,
    vec_mem_streamer_if.slave bus
);
    localparam int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE);
    localparam int CNT_W           = CACHE_ADDR_SIZE + 1;
    localparam logic [CACHE_ADDR_SIZE-1:0] LAST_IDX = CACHE_ADDR_SIZE'(CACHE_SIZE - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STORE_RD, STORE_WR, DONE} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [DATA_MEM_ADDR_SIZE-1:0] r_mem_addr;
    logic [DATA_MEM_ADDR_SIZE-1:0] r_stride;
    logic [CACHE_ADDR_SIZE-1:0]    r_cache_ptr;
    logic [CACHE_ADDR_SIZE-1:0]    w_cache_ptr_inc;
    logic [CNT_W-1:0]              r_left;
    logic                          r_error;
    logic                          w_req_bad;
    logic                          w_req_zero;
    logic                          w_accept;
    logic                          w_step;
    logic [WIDTH-1:0][31:0]        w_load_data;
    logic [WIDTH-1:0][31:0]        w_store_data;

    assign w_req_bad       = bus.start && (bus.count > CNT_W'(CACHE_SIZE));
    assign w_req_zero      = bus.start && (bus.count == '0);
    assign w_accept        = (r_state == IDLE) && bus.start && !w_req_bad && !w_req_zero;
    assign w_step          = (r_state == LOAD) || (r_state == STORE_WR);
    // explicit wrap so non-power-of-two cache sizes still index correctly
    assign w_cache_ptr_inc = (r_cache_ptr == LAST_IDX) ? '0 : r_cache_ptr + 1'b1;
    assign w_load_data     = bus.data_mem_data_out;
    assign w_store_data    = bus.cache_data_out;
    assign bus.error       = r_error;

    // State register; reset drops straight to IDLE so all outputs fall at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; outputs are zero outside their active state
    always_comb begin
        w_state_nxt             = r_state;
        bus.busy                = 1'b1;
        bus.done                = 1'b0;
        bus.data_mem_read_addr  = '0;
        bus.data_mem_write_en   = 1'b0;
        bus.data_mem_write_addr = '0;
        bus.data_mem_data_in    = '0;
        bus.cache_read_addr     = '0;
        bus.cache_write_en      = 1'b0;
        bus.cache_write_addr    = '0;
        bus.cache_data_in       = '0;
        case (r_state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start && !w_req_bad) begin
                    if (w_req_zero) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = bus.mode ? STORE_RD : LOAD;
                    end
                end
            end
            LOAD: begin
                bus.data_mem_read_addr = r_mem_addr;
                bus.cache_write_en     = 1'b1;
                bus.cache_write_addr   = r_cache_ptr;
                bus.cache_data_in      = w_load_data;
                if (r_left == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            STORE_RD: begin
                bus.cache_read_addr = r_cache_ptr;
                w_state_nxt         = STORE_WR;
            end
            STORE_WR: begin
                bus.cache_read_addr     = r_cache_ptr;
                bus.data_mem_write_en   = 1'b1;
                bus.data_mem_write_addr = r_mem_addr;
                bus.data_mem_data_in    = w_store_data;
                if (r_left == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, running address/index pointers and remaining-vector down-counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_stride    <= '0;
            r_cache_ptr <= '0;
            r_left      <= '0;
            r_error     <= 1'b0;
        end else begin
            r_error <= (r_state == IDLE) && w_req_bad;
            if (w_accept) begin
                r_mem_addr  <= bus.mem_base;
                r_stride    <= bus.mem_stride;
                r_cache_ptr <= bus.cache_base;
                r_left      <= bus.count;
            end else if (r_state == STORE_RD) begin
                r_cache_ptr <= w_cache_ptr_inc;
            end else if (w_step) begin
                r_mem_addr  <= r_mem_addr + r_stride;
                r_cache_ptr <= w_cache_ptr_inc;
                r_left      <= r_left - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vec_mem_streamer.sv
// Bench for vec_mem_streamer: data memory with address-derived contents,
// registered-read cache model, and write scoreboards fed at request time.
module tb_vec_mem_streamer;
    typedef logic [15:0][31:0] vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] raddr;
        vec_t        data;
    } wr_t;

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] mb;
        logic [31:0] s;
        logic [2:0]  cb;
        logic [3:0]  cnt;
        logic        exp_err;
        int          exp_cyc;
        int          exp_wr;
    } vec_rec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int n_tests    = 0;
    int n_fail     = 0;
    int n_cache_wr = 0;
    int n_mem_wr   = 0;
    int n_done     = 0;

    wr_t  q_cache[$];
    wr_t  q_mem[$];
    vec_t cache_mem [8];
    vec_t r_cache_q;

    vec_mem_streamer_if #(.WIDTH(16), .CACHE_SIZE(8), .DATA_MEM_ADDR_SIZE(32)) bus ();

    vec_mem_streamer #(.WIDTH(16), .CACHE_SIZE(8), .DATA_MEM_ADDR_SIZE(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t pat(input logic [31:0] a);
        vec_t v;
        for (int k = 0; k < 16; k++) v[k] = a ^ (32'(k) << 24) ^ 32'h0055_AA00;
        return v;
    endfunction

    assign bus.data_mem_data_out = pat(bus.data_mem_read_addr);
    assign bus.cache_data_out    = r_cache_q;

    always @(posedge clock) begin
        if (bus.cache_write_en) cache_mem[bus.cache_write_addr] <= bus.cache_data_in;
        r_cache_q <= cache_mem[bus.cache_read_addr];
    end

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (bus.cache_write_en) begin
            n_cache_wr++;
            if (q_cache.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_cache_write: got addr %0h expected none", bus.cache_write_addr);
            end else begin
                e = q_cache.pop_front();
                check("cache_wr_addr", 512'(bus.cache_write_addr), 512'(e.addr));
                check("mem_rd_addr", 512'(bus.data_mem_read_addr), 512'(e.raddr));
                check("cache_wr_data", bus.cache_data_in, e.data);
            end
        end
        if (bus.data_mem_write_en) begin
            n_mem_wr++;
            if (q_mem.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_mem_write: got addr %0h expected none", bus.data_mem_write_addr);
            end else begin
                e = q_mem.pop_front();
                check("mem_wr_addr", 512'(bus.data_mem_write_addr), 512'(e.addr));
                check("mem_wr_data", bus.data_mem_data_in, e.data);
            end
        end
        if (bus.done) n_done++;
    end

    task automatic push_expected(input logic m, input logic [31:0] mb, input logic [31:0] s,
                                 input logic [2:0] cb, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            if (!m) begin
                e.addr  = 32'((int'(cb) + i) % 8);
                e.raddr = mb + 32'(i) * s;
                e.data  = pat(e.raddr);
                q_cache.push_back(e);
            end else begin
                e.addr  = mb + 32'(i) * s;
                e.raddr = '0;
                e.data  = cache_mem[(int'(cb) + i) % 8];
                q_mem.push_back(e);
            end
        end
    endtask

    task automatic do_xfer(input string nm, input logic m, input logic [31:0] mb, input logic [31:0] s,
                           input logic [2:0] cb, input logic [3:0] cnt, input logic exp_err,
                           input int exp_cyc, input int exp_wr, input int disturb_k);
        int   wr0;
        int   cyc;
        logic found;
        logic got_err;
        logic busy_wrong;
        wr0        = n_cache_wr + n_mem_wr;
        found      = 1'b0;
        got_err    = 1'b0;
        busy_wrong = 1'b0;
        cyc        = 0;
        if (!exp_err) push_expected(m, mb, s, cb, int'(cnt));
        @(negedge clock);
        bus.start      = 1'b1;
        bus.mode       = m;
        bus.mem_base   = mb;
        bus.mem_stride = s;
        bus.cache_base = cb;
        bus.count      = cnt;
        for (int k = 1; k <= 64 && !found; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == disturb_k) begin
                bus.start      = 1'b1;
                bus.mode       = ~m;
                bus.mem_base   = 32'h0000_0999;
                bus.cache_base = 3'd7;
                bus.count      = 4'd2;
            end else begin
                bus.start = 1'b0;
            end
            if (exp_err ? bus.busy : !bus.busy) busy_wrong = 1'b1;
            if (bus.done) begin
                found = 1'b1; cyc = k;
            end else if (bus.error) begin
                found = 1'b1; cyc = k; got_err = 1'b1;
            end
        end
        check({nm, "_completed"}, 512'(found), 512'(1));
        check({nm, "_error"}, 512'(got_err), 512'(exp_err));
        check({nm, "_cycles"}, 512'(cyc), 512'(exp_cyc));
        check({nm, "_busy"}, 512'(busy_wrong), 512'(0));
        check({nm, "_writes"}, 512'(n_cache_wr + n_mem_wr - wr0), 512'(exp_wr));
        check({nm, "_sb_empty"}, 512'(q_cache.size() + q_mem.size()), 512'(0));
        @(negedge clock);
        check({nm, "_pulse_end"}, 512'({bus.done, bus.error, bus.busy}), 512'(0));
    endtask

    vec_rec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        int d0;
        tv[0] = '{"load_cache_wrap", 1'b0, 32'd4,          32'd1,      3'd6, 4'd3, 1'b0, 4,  3};
        tv[1] = '{"load_stride3",    1'b0, 32'd200,        32'd3,      3'd1, 4'd3, 1'b0, 4,  3};
        tv[2] = '{"store_stride2",   1'b1, 32'd100,        32'd2,      3'd0, 4'd4, 1'b0, 6,  4};
        tv[3] = '{"load_count0",     1'b0, 32'd7,          32'd1,      3'd0, 4'd0, 1'b0, 1,  0};
        tv[4] = '{"reject_count9",   1'b0, 32'd0,          32'd1,      3'd0, 4'd9, 1'b1, 1,  0};
        tv[5] = '{"load_addr_wrap",  1'b0, 32'hFFFF_FFFF,  32'd1,      3'd4, 4'd2, 1'b0, 3,  2};
        tv[6] = '{"store_full_wrap", 1'b1, 32'hFFFF_FFF0,  32'd8,      3'd5, 4'd8, 1'b0, 10, 8};
        tv[7] = '{"load_full",       1'b0, 32'h1000_0000,  32'h1000,   3'd3, 4'd8, 1'b0, 9,  8};
        tv[8] = '{"store_count0",    1'b1, 32'd50,         32'd1,      3'd2, 4'd0, 1'b0, 1,  0};
        tv[9] = '{"reject_count15",  1'b1, 32'd0,          32'd1,      3'd0, 4'd15, 1'b1, 1, 0};

        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.mem_base   = '0;
        bus.mem_stride = '0;
        bus.cache_base = '0;
        bus.count      = '0;

        #1 reset = 1'b1;
        #2;
        check("reset_outputs", 512'({bus.busy, bus.done, bus.error, bus.cache_write_en,
                                      bus.data_mem_write_en, bus.data_mem_read_addr,
                                      bus.data_mem_write_addr, bus.cache_read_addr,
                                      bus.cache_write_addr}), 512'(0));
        repeat (3) @(negedge clock);
        reset = 1'b0;

        for (int t = 0; t < 10; t++) begin
            do_xfer(tv[t].name, tv[t].mode, tv[t].mb, tv[t].s, tv[t].cb, tv[t].cnt,
                    tv[t].exp_err, tv[t].exp_cyc, tv[t].exp_wr, 0);
        end

        // start with a different request pulsed while STORE_WR is running
        do_xfer("store_ignore_start", 1'b1, 32'd300, 32'd1, 3'd0, 4'd4, 1'b0, 6, 4, 2);

        // reset after two of five LOAD vectors have been written
        push_expected(1'b0, 32'd50, 32'd1, 3'd2, 2);
        wr0 = n_cache_wr;
        d0  = n_done;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.mode       = 1'b0;
        bus.mem_base   = 32'd50;
        bus.mem_stride = 32'd1;
        bus.cache_base = 3'd2;
        bus.count      = 4'd5;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_outputs_zero", 512'({bus.busy, bus.done, bus.error, bus.cache_write_en,
                                          bus.data_mem_write_en, bus.data_mem_read_addr,
                                          bus.cache_write_addr}), 512'(0));
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("abort_cache_writes", 512'(n_cache_wr - wr0), 512'(2));
        check("abort_no_done", 512'(n_done - d0), 512'(0));
        check("abort_sb_empty", 512'(q_cache.size()), 512'(0));
        do_xfer("after_abort_load", 1'b0, 32'd60, 32'd1, 3'd0, 4'd2, 1'b0, 3, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_mem_streamer.md
VEC_MEM_STREAMER -- requirements
Module: vec_mem_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of 32-bit float lanes per vector.
REQ-002 SHALL have parameter CACHE_SIZE, default 8, number of vector cache entries; CACHE_ADDR_SIZE = $clog2(CACHE_SIZE).
REQ-003 SHALL have parameter DATA_MEM_ADDR_SIZE, default 32, data-memory vector address width.
REQ-004 SHALL have ports:
 clock  input  1  rising-edge clock
 reset  input  1  asynchronous, active-high reset
 start  input  1  transfer request, sampled in IDLE only
 mode  input  1  0 = LOAD (mem->cache), 1 = STORE (cache->mem)
 mem_base  input  DATA_MEM_ADDR_SIZE  first data-memory vector address
 mem_stride  input  DATA_MEM_ADDR_SIZE  address increment per vector
 cache_base  input  CACHE_ADDR_SIZE  first cache entry
 count  input  CACHE_ADDR_SIZE+1  vectors to move
 busy  output  1  high while transfer in progress
 done  output  1  one-cycle completion pulse
 error  output  1  one-cycle pulse on rejected request
 data_mem_read_addr  output  DATA_MEM_ADDR_SIZE  combinational-read address
 data_mem_data_out  input  WIDTH x 32  read data, same cycle
 data_mem_write_en  output  1  memory write strobe
 data_mem_write_addr  output  DATA_MEM_ADDR_SIZE  write address
 data_mem_data_in  output  WIDTH x 32  write data
 cache_read_addr  output  CACHE_ADDR_SIZE  cache read address, data returned next cycle
 cache_data_out  input  WIDTH x 32  cache read data
 cache_write_en  output  1  cache write strobe
 cache_write_addr  output  CACHE_ADDR_SIZE  cache write address
 cache_data_in  output  WIDTH x 32  cache write data

Function
REQ-005 SHALL implement states IDLE, LOAD, STORE_RD, STORE_WR, DONE.
REQ-006 In IDLE with start=1: count > CACHE_SIZE -> pulse error next cycle, stay IDLE; count = 0 -> go DONE; else latch all request inputs, go LOAD (mode 0) or STORE_RD (mode 1).
REQ-007 LOAD SHALL move one vector per cycle: data_mem_read_addr = mem_base + i*mem_stride, cache_write_en=1, cache_write_addr = (cache_base + i) mod CACHE_SIZE, cache_data_in = data_mem_data_out, for i = 0..count-1; then DONE.
REQ-008 STORE SHALL pipeline one vector per cycle: STORE_RD issues cache_read_addr for i=0; STORE_WR each cycle writes vector i-1 (data_mem_write_en=1, address mem_base + (i-1)*mem_stride, data = cache_data_out) while issuing read i; total count+1 cycles from first read to DONE.
REQ-009 Address arithmetic SHALL wrap modulo 2^DATA_MEM_ADDR_SIZE; cache index SHALL wrap modulo CACHE_SIZE.
REQ-010 busy SHALL be 1 in LOAD, STORE_RD, STORE_WR and DONE; 0 in IDLE.
REQ-011 DONE SHALL assert done for exactly one cycle, then return to IDLE; a new start is accepted the cycle after.
REQ-012 start asserted while busy SHALL be ignored; request inputs changing while busy SHALL not affect the transfer.
REQ-013 Write strobes SHALL be 0 in every state except LOAD (cache) and STORE_WR (memory); no write SHALL occur for count = 0 or rejected requests.

Reset
REQ-014 reset=1 SHALL immediately force IDLE, busy=0, done=0, error=0, both write strobes 0, all address outputs 0, independent of clock.
REQ-015 Reset mid-transfer SHALL abort without completing further writes and without a done pulse.

Verification
REQ-016 LOAD mem_base=4, stride=1, cache_base=6, count=3 -> cache entries 6,7,0 get mem[4],mem[5],mem[6]; done 4 cycles after start accepted.
REQ-017 STORE cache_base=0, mem_base=100, stride=2, count=4 -> mem[100,102,104,106] = cache[0..3]; exactly 4 write strobes; done once.
REQ-018 count=0 -> done pulse, no write strobes; count=9 (CACHE_SIZE=8) -> error pulse, busy stays 0.
REQ-019 start pulsed during STORE_WR with different mode/base -> ignored; original transfer results unchanged.
REQ-020 reset asserted mid-LOAD after 2 of 5 vectors -> only 2 cache writes, outputs zero asynchronously, no done; subsequent request completes normally.
REQ-021 mem_base=2^32-1, stride=1, count=2 -> addresses 0xFFFFFFFF then 0x00000000.
